midi_note_rx: RTL

Serial MIDI front end for the synthesizer voice: receives a 31250-baud MIDI stream, decodes Note On/Note Off messages on one channel, and drives the 8-bit NOTE code consumed by the note-to-phase-increment stage. It also provides a gate, velocity and event strobe. It is the producer end of the NOTE interface.

---
 rtl/midi_note_rx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/midi_note_rx.sv
// ============================================================================
// midi_note_rx : 8N1 MIDI receiver and single-channel Note On/Off decoder
// Revision     : 1.0
// ============================================================================
`default_nettype none

module midi_note_rx #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BAUD    = 31250,
  parameter int CHANNEL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_in,
  output logic [7:0] note,
  output logic [6:0] velocity,
  output logic       gate,
  output logic       note_strobe,
  output logic       frame_err
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [3:0]    CH       = 4'(CHANNEL);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] P_NONE = 2'd0;
  localparam logic [1:0] P_D1   = 2'd1;
  localparam logic [1:0] P_D2   = 2'd2;

  localparam logic [1:0] K_ON    = 2'd0;
  localparam logic [1:0] K_OFF   = 2'd1;
  localparam logic [1:0] K_SKIP1 = 2'd2;
  localparam logic [1:0] K_SKIP2 = 2'd3;

  logic          sync1, sync2, prev_s;
  logic [1:0]    rx_state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          byte_valid;

  logic [1:0]    p_state;
  logic [1:0]    kind;
  logic [6:0]    d1;

  // Synchronizer and edge-history flops reset high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      prev_s     <= 1'b1;
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_cnt    <= 3'd0;
      shift      <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1      <= midi_in;
      sync2      <= sync1;
      prev_s     <= sync2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (prev_s && !sync2) begin
            rx_state <= RX_START;
            cnt      <= '0;
            bit_cnt  <= 3'd0;
          end
        end
        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt      <= '0;
            rx_state <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt     <= '0;
            shift   <= {sync2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == CNT_FULL) begin
            cnt      <= '0;
            rx_state <= RX_IDLE;
            if (sync2) byte_valid <= 1'b1;
            else       frame_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state     <= P_NONE;
      kind        <= K_SKIP2;
      d1          <= 7'd0;
      note        <= 8'd0;
      velocity    <= 7'd0;
      gate        <= 1'b0;
      note_strobe <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      if (byte_valid) begin
        if (shift[7]) begin
          // Real-time bytes (F8-FF) fall through untouched.
          if (shift[7:3] != 5'b11111) begin
            if (shift[7:4] == 4'hF) begin
              p_state <= P_NONE;
            end else begin
              p_state <= P_D1;
              if (shift == {4'h8, CH})                          kind <= K_OFF;
              else if (shift == {4'h9, CH})                     kind <= K_ON;
              else if (shift[7:4] == 4'hC || shift[7:4] == 4'hD) kind <= K_SKIP1;
              else                                               kind <= K_SKIP2;
            end
          end
        end else begin
          case (p_state)
            P_D1: begin
              d1      <= shift[6:0];
              p_state <= (kind == K_SKIP1) ? P_D1 : P_D2;
            end
            P_D2: begin
              p_state <= P_D1;
              if (kind == K_ON && shift[6:0] != 7'd0) begin
                note        <= {1'b0, d1};
                velocity    <= shift[6:0];
                gate        <= 1'b1;
                note_strobe <= 1'b1;
              end else if (kind == K_ON || kind == K_OFF) begin
                if (gate && d1 == note[6:0]) gate <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire
